// File: rtl/fix_pkg.sv
// rtl/fix_pkg.sv - shared constants, parser state type and digit helper for the FIX value packer
package fix_pkg;
  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] EQ = 8'h3D;
  localparam int CKSUM_TAG = 10;
  localparam int MAX_TAG_DIGITS = 5;

  typedef enum logic [1:0] {
    TAG,
    VALUE,
    SKIP
  } state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction
endpackage

// File: rtl/fix_cksum_acc.sv
// rtl/fix_cksum_acc.sv - mod-256 FIX checksum accumulator and tag 10 compare (used only with FIX_CHECKSUM_EN)
module fix_cksum_acc
  import fix_pkg::*;
#(
  parameter int TAG_WIDTH = 17,
  parameter int LEN_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           byte_i,
  input  logic                 add_i,
  input  logic                 drop_i,
  input  logic                 commit_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  input  logic [23:0]          val_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 ok_o,
  output logic                 err_o
);
  logic [7:0] field_q, field_d;
  logic [7:0] comm_q, comm_d;
  logic       ok_q, ok_d;
  logic       err_q, err_d;
  logic       dec_ok;
  logic [9:0] dec_val;

  always_comb begin
    field_d = field_q;
    comm_d  = comm_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    dec_ok  = is_digit(val_i[7:0]) && is_digit(val_i[15:8]) && is_digit(val_i[23:16])
              && (len_i == LEN_WIDTH'(3));
    dec_val = 10'(val_i[7:0] - 8'h30) * 10'd100 + 10'(val_i[15:8] - 8'h30) * 10'd10
              + 10'(val_i[23:16] - 8'h30);
    if (drop_i) begin
      field_d = 8'd0;
    end else if (add_i) begin
      field_d = field_q + byte_i;
    end else if (commit_i) begin
      field_d = 8'd0;
      // The checksum field itself never feeds the running sum
      if (tag_i == TAG_WIDTH'(CKSUM_TAG)) begin
        comm_d = 8'd0;
        if (dec_ok && (dec_val == {2'b00, comm_q})) ok_d = 1'b1;
        else err_d = 1'b1;
      end else begin
        comm_d = comm_q + field_q + byte_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      field_q <= 8'd0;
      comm_q  <= 8'd0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      field_q <= field_d;
      comm_q  <= comm_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign ok_o  = ok_q;
  assign err_o = err_q;
endmodule

// File: rtl/fix_value_packer.sv
// rtl/fix_value_packer.sv - parses FIX tag=value<SOH> fields and issues one packed RAM write per field
// Optional checksum compare is built when FIX_CHECKSUM_EN is defined.
module fix_value_packer
  import fix_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 5,
  parameter int TAG_WIDTH  = 17,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  we_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic [LEN_WIDTH-1:0]  len_o,
  output logic [ADDR_WIDTH-1:0] field_idx_o,
  output logic                  trunc_o,
  output logic                  fmt_err_o,
  output logic                  cksum_ok_o,
  output logic                  cksum_err_o
);
  localparam int LANE_W = $clog2(DATA_WIDTH / 8);
  localparam logic [LEN_WIDTH-1:0] CAP = LEN_WIDTH'(DATA_WIDTH / 8);

  state_e                state_q, state_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [2:0]            ndig_q, ndig_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  trunc_q, trunc_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  we_q, we_d;
  logic                  fmt_err_q, fmt_err_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
  logic [LEN_WIDTH-1:0]  out_len_q, out_len_d;
  logic [ADDR_WIDTH-1:0] out_idx_q, out_idx_d;
  logic                  out_trunc_q, out_trunc_d;
  logic                  ck_add, ck_drop, ck_commit;

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    ndig_d      = ndig_q;
    len_d       = len_q;
    data_d      = data_q;
    trunc_d     = trunc_q;
    idx_d       = idx_q;
    we_d        = 1'b0;
    fmt_err_d   = 1'b0;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_len_d   = out_len_q;
    out_idx_d   = out_idx_q;
    out_trunc_d = 1'b0;
    ck_add      = 1'b0;
    ck_drop     = 1'b0;
    ck_commit   = 1'b0;
    if (byte_valid_i) begin
      case (state_q)
        TAG: begin
          if (is_digit(byte_i) && (ndig_q != 3'(MAX_TAG_DIGITS))) begin
            tag_d  = tag_q * TAG_WIDTH'(10) + TAG_WIDTH'(byte_i - 8'h30);
            ndig_d = ndig_q + 3'd1;
            ck_add = 1'b1;
          end else if ((byte_i == EQ) && (ndig_q != 3'd0)) begin
            state_d = VALUE;
            len_d   = '0;
            data_d  = '0;
            ck_add  = 1'b1;
          end else begin
            state_d   = SKIP;
            fmt_err_d = 1'b1;
            tag_d     = '0;
            ndig_d    = 3'd0;
            ck_drop   = 1'b1;
          end
        end
        VALUE: begin
          if (byte_i == SOH) begin
            we_d        = 1'b1;
            out_data_d  = data_q;
            out_tag_d   = tag_q;
            out_len_d   = len_q;
            out_idx_d   = idx_q;
            out_trunc_d = trunc_q;
            idx_d       = idx_q + ADDR_WIDTH'(1);
            tag_d       = '0;
            ndig_d      = 3'd0;
            len_d       = '0;
            trunc_d     = 1'b0;
            state_d     = TAG;
            ck_commit   = 1'b1;
          end else begin
            ck_add = 1'b1;
            // Bytes beyond capacity are dropped but remembered as truncation
            if (len_q == CAP) begin
              trunc_d = 1'b1;
            end else begin
              data_d[{len_q[LANE_W-1:0], 3'b000} +: 8] = byte_i;
              len_d = len_q + LEN_WIDTH'(1);
            end
          end
        end
        SKIP: begin
          if (byte_i == SOH) state_d = TAG;
        end
        default: state_d = TAG;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= TAG;
      tag_q       <= '0;
      ndig_q      <= 3'd0;
      len_q       <= '0;
      data_q      <= '0;
      trunc_q     <= 1'b0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      fmt_err_q   <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_len_q   <= '0;
      out_idx_q   <= '0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      ndig_q      <= ndig_d;
      len_q       <= len_d;
      data_q      <= data_d;
      trunc_q     <= trunc_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      fmt_err_q   <= fmt_err_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_len_q   <= out_len_d;
      out_idx_q   <= out_idx_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign we_o        = we_q;
  assign data_o      = out_data_q;
  assign tag_o       = out_tag_q;
  assign len_o       = out_len_q;
  assign field_idx_o = out_idx_q;
  assign trunc_o     = out_trunc_q;
  assign fmt_err_o   = fmt_err_q;

`ifdef FIX_CHECKSUM_EN
  fix_cksum_acc #(
    .TAG_WIDTH(TAG_WIDTH),
    .LEN_WIDTH(LEN_WIDTH)
  ) u_cksum (
    .clk      (clk),
    .rst      (rst),
    .byte_i   (byte_i),
    .add_i    (ck_add),
    .drop_i   (ck_drop),
    .commit_i (ck_commit),
    .tag_i    (tag_q),
    .val_i    (data_q[23:0]),
    .len_i    (len_q),
    .ok_o     (cksum_ok_o),
    .err_o    (cksum_err_o)
  );
`else
  logic unused_ck;
  assign unused_ck   = ^{ck_add, ck_drop, ck_commit};
  assign cksum_ok_o  = 1'b0;
  assign cksum_err_o = 1'b0;
`endif
endmodule
